dog_sprite_renderer: RTL and testbench

Pixel-generation stage downstream of the game physics core. It snapshots the two active dogs' position, colour and hit count once per frame on `frame_tick`, then compares every VGA pixel coordinate against the two bounding boxes. It outputs an RGB222 pixel plus sync/enable signals, delayed so they stay aligned with the pixel. A per-dog hit-flash timer briefly renders a dog white after its hit counter changes.

---
 rtl/dog_sprite_renderer.sv | 185 ++++++++++++++++++
 tb/tb_dog_sprite_renderer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dog_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module   : dog_sprite_renderer
// Brief    : Per-frame snapshot of two dog sprites and a 2-stage RGB222 pixel
//            pipeline. Optional hit-flash build macro: DOG_RENDER_FLASH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dog_sprite_renderer #(
  parameter int         BOX_W        = 48,
  parameter int         BOX_H        = 32,
  parameter logic [5:0] BG_RGB       = 6'b000001,
  parameter int         FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] posx0,
  input  logic [9:0] posx1,
  input  logic [8:0] posy0,
  input  logic [8:0] posy1,
  input  logic [2:0] color_idx0,
  input  logic [2:0] color_idx1,
  input  logic [7:0] hits0,
  input  logic [7:0] hits1,
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);

  localparam logic [10:0] c_box_w = 11'(BOX_W);
  localparam logic [10:0] c_box_h = 11'(BOX_H);

  function automatic logic [5:0] palette(input logic [2:0] idx);
    logic [5:0] col;
    col = 6'b000000;
    case (idx)
      3'd0: col = 6'b000000;
      3'd1: col = 6'b110000;
      3'd2: col = 6'b001100;
      3'd3: col = 6'b000011;
      3'd4: col = 6'b111100;
      3'd5: col = 6'b001111;
      3'd6: col = 6'b110011;
      3'd7: col = 6'b111111;
      default: col = 6'b000000;
    endcase
    return col;
  endfunction

  logic [9:0] r_x0, r_x1;
  logic [8:0] r_y0, r_y1;
  logic [2:0] r_idx0, r_idx1;
  logic       r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_idx0  <= '0;
      r_idx1  <= '0;
      r_valid <= 1'b0;
    end else if (frame_tick) begin
      r_x0    <= posx0;
      r_x1    <= posx1;
      r_y0    <= posy0;
      r_y1    <= posy1;
      r_idx0  <= color_idx0;
      r_idx1  <= color_idx1;
      r_valid <= 1'b1;
    end
  end

  logic w_flash_on0, w_flash_on1;

`ifdef DOG_RENDER_FLASH_EN
  localparam logic [3:0] c_flash_load = 4'(FLASH_FRAMES);

  logic [7:0] r_hits0, r_hits1;
  logic [3:0] r_flash0, r_flash1;

  // A hit change reloads the timer; otherwise it counts down once per frame.
  function automatic logic [3:0] flash_next(input logic [3:0] cur, input logic [7:0] hin,
                                            input logic [7:0] hold, input logic valid);
    logic [3:0] nxt;
    nxt = 4'd0;
    if (valid && (hin != hold)) nxt = c_flash_load;
    else if (cur != 4'd0)       nxt = cur - 4'd1;
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits0  <= '0;
      r_hits1  <= '0;
      r_flash0 <= '0;
      r_flash1 <= '0;
    end else if (frame_tick) begin
      r_hits0  <= hits0;
      r_hits1  <= hits1;
      r_flash0 <= flash_next(r_flash0, hits0, r_hits0, r_valid);
      r_flash1 <= flash_next(r_flash1, hits1, r_hits1, r_valid);
    end
  end

  assign w_flash_on0 = (r_flash0 != 4'd0);
  assign w_flash_on1 = (r_flash1 != 4'd0);
`else
  wire [19:0] w_unused_hits = {hits0, hits1, 4'(FLASH_FRAMES)};
  assign w_flash_on0 = 1'b0;
  assign w_flash_on1 = 1'b0;
`endif

  // 11-bit compares keep boxes near the right/bottom edge from wrapping.
  logic [10:0] w_h, w_v;
  logic        w_in0, w_in1;
  always_comb begin
    w_h   = {1'b0, hcount};
    w_v   = {1'b0, vcount};
    w_in0 = r_valid && (w_h >= {1'b0, r_x0}) && (w_h < ({1'b0, r_x0} + c_box_w)) &&
            (w_v >= {2'b0, r_y0}) && (w_v < ({2'b0, r_y0} + c_box_h));
    w_in1 = r_valid && (w_h >= {1'b0, r_x1}) && (w_h < ({1'b0, r_x1} + c_box_w)) &&
            (w_v >= {2'b0, r_y1}) && (w_v < ({2'b0, r_y1} + c_box_h));
  end

  logic       r_in0_s1, r_in1_s1, r_de_s1, r_hs_s1, r_vs_s1, r_fl0_s1, r_fl1_s1;
  logic [2:0] r_idx0_s1, r_idx1_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in0_s1  <= 1'b0;
      r_in1_s1  <= 1'b0;
      r_de_s1   <= 1'b0;
      r_hs_s1   <= 1'b0;
      r_vs_s1   <= 1'b0;
      r_fl0_s1  <= 1'b0;
      r_fl1_s1  <= 1'b0;
      r_idx0_s1 <= '0;
      r_idx1_s1 <= '0;
    end else begin
      r_in0_s1  <= w_in0;
      r_in1_s1  <= w_in1;
      r_de_s1   <= display_on;
      r_hs_s1   <= hsync_in;
      r_vs_s1   <= vsync_in;
      r_fl0_s1  <= w_flash_on0;
      r_fl1_s1  <= w_flash_on1;
      r_idx0_s1 <= r_idx0;
      r_idx1_s1 <= r_idx1;
    end
  end

  logic [5:0] w_col0, w_col1, w_pix;
  always_comb begin
    w_col0 = r_fl0_s1 ? 6'b111111 : palette(r_idx0_s1);
    w_col1 = r_fl1_s1 ? 6'b111111 : palette(r_idx1_s1);
    if (!r_de_s1)      w_pix = 6'b000000;
    else if (r_in0_s1) w_pix = w_col0;
    else if (r_in1_s1) w_pix = w_col1;
    else               w_pix = BG_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      de    <= 1'b0;
    end else begin
      rgb   <= w_pix;
      hsync <= r_hs_s1;
      vsync <= r_vs_s1;
      de    <= r_de_s1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dog_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dog_sprite_renderer
// Brief    : Directed self-checking bench for dog_sprite_renderer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dog_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] hcount = '0, vcount = '0;
  logic       display_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [9:0] posx0 = '0, posx1 = '0;
  logic [8:0] posy0 = '0, posy1 = '0;
  logic [2:0] color_idx0 = '0, color_idx1 = '0;
  logic [7:0] hits0 = '0, hits1 = '0;
  logic [5:0] rgb;
  logic       hsync, vsync, de;

  int n_cmp = 0;
  int n_err = 0;

  dog_sprite_renderer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .hcount(hcount), .vcount(vcount), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .posx0(posx0), .posx1(posx1), .posy0(posy0), .posy1(posy1),
    .color_idx0(color_idx0), .color_idx1(color_idx1),
    .hits0(hits0), .hits1(hits1),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de)
  );

  always #5 clk = ~clk;

  // Present one pixel and wait out the two-clock latency.
  task automatic show(input int h, input int v, input logic d, input logic hs, input logic vs);
    @(negedge clk);
    hcount = 10'(h); vcount = 10'(v); display_on = d; hsync_in = hs; vsync_in = vs;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic set_dogs(input int x0, input int y0, input int i0,
                          input int x1, input int y1, input int i1);
    posx0 = 10'(x0); posy0 = 9'(y0); color_idx0 = 3'(i0);
    posx1 = 10'(x1); posy1 = 9'(y1); color_idx1 = 3'(i1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({rgb, hsync, vsync, de} !== 9'b0) begin
      n_err++; $display("FAIL reset_outputs got=%b want=%b", {rgb, hsync, vsync, de}, 9'b0);
    end
    #20; @(negedge clk); rst_n = 1'b1;
    set_dogs(100, 100, 1, 400, 300, 3);
    show(100, 100, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b000001 || de !== 1'b1) begin
      n_err++; $display("FAIL bg_before_tick rgb=%b de=%b want 000001/1", rgb, de);
    end
    show(100, 100, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (rgb !== 6'b000000 || de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b0) begin
      n_err++; $display("FAIL blank_sync rgb=%b de=%b hs=%b vs=%b want 000000/0/1/0", rgb, de, hsync, vsync);
    end
    show(5, 5, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (hsync !== 1'b0 || vsync !== 1'b1 || de !== 1'b1) begin
      n_err++; $display("FAIL sync_pass hs=%b vs=%b de=%b want 0/1/1", hsync, vsync, de);
    end
  endtask

  task automatic test_two_dogs();
    int px[8] = '{100, 147, 148, 400, 447, 100, 99, 400};
    int py[8] = '{100, 131, 131, 300, 331, 99, 100, 332};
    logic [5:0] ex[8] = '{6'b110000, 6'b110000, 6'b000001, 6'b000011,
                          6'b000011, 6'b000001, 6'b000001, 6'b000001};
    set_dogs(100, 100, 1, 400, 300, 3);
    tick();
    for (int i = 0; i < 8; i++) begin
      show(px[i], py[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (rgb !== ex[i]) begin
        n_err++; $display("FAIL two_dogs(%0d,%0d) rgb=%b want=%b", px[i], py[i], rgb, ex[i]);
      end
    end
  endtask

  task automatic test_overlap();
    set_dogs(200, 200, 2, 220, 210, 4);
    tick();
    show(230, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b001100) begin
      n_err++; $display("FAIL overlap_dog0 rgb=%b want=001100", rgb);
    end
    show(260, 235, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b111100) begin
      n_err++; $display("FAIL overlap_dog1 rgb=%b want=111100", rgb);
    end
  endtask

  task automatic test_no_tearing();
    posx0 = 10'd0;
    show(10, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b000001) begin
      n_err++; $display("FAIL tear_new_pos rgb=%b want=000001", rgb);
    end
    show(230, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b001100) begin
      n_err++; $display("FAIL tear_old_pos rgb=%b want=001100", rgb);
    end
    tick();
    show(10, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b001100) begin
      n_err++; $display("FAIL moved_new_pos rgb=%b want=001100", rgb);
    end
    show(230, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b111100) begin
      n_err++; $display("FAIL moved_old_pos rgb=%b want=111100", rgb);
    end
  endtask

  task automatic test_tick_coincident();
    posx0 = 10'd500;
    @(negedge clk);
    hcount = 10'd10; vcount = 10'd215; display_on = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (rgb !== 6'b001100) begin
      n_err++; $display("FAIL tick_pixel_old rgb=%b want=001100", rgb);
    end
    show(510, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b001100) begin
      n_err++; $display("FAIL tick_pixel_new rgb=%b want=001100", rgb);
    end
  endtask

  task automatic test_edges();
    set_dogs(1000, 200, 2, 220, 500, 4);
    tick();
    show(1010, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b001100) begin
      n_err++; $display("FAIL right_edge rgb=%b want=001100", rgb);
    end
    show(10, 215, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b000001) begin
      n_err++; $display("FAIL no_wrap_x rgb=%b want=000001", rgb);
    end
    show(230, 530, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b111100) begin
      n_err++; $display("FAIL bottom_edge rgb=%b want=111100", rgb);
    end
    show(230, 5, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b000001) begin
      n_err++; $display("FAIL no_wrap_y rgb=%b want=000001", rgb);
    end
  endtask

  task automatic test_flash();
    logic [5:0] exp_c;
    set_dogs(100, 100, 1, 400, 300, 3);
    hits0 = 8'd1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      show(110, 110, 1'b1, 1'b0, 1'b0);
`ifdef DOG_RENDER_FLASH_EN
      exp_c = (k <= 8) ? 6'b111111 : 6'b110000;
`else
      exp_c = 6'b110000;
`endif
      n_cmp++;
      if (rgb !== exp_c) begin
        n_err++; $display("FAIL flash_frame%0d rgb=%b want=%b", k, rgb, exp_c);
      end
    end
    show(410, 310, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b000011) begin
      n_err++; $display("FAIL flash_dog1_steady rgb=%b want=000011", rgb);
    end
  endtask

  task automatic test_mid_reset();
    show(110, 110, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (rgb !== 6'b110000 || hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b1) begin
      n_err++; $display("FAIL pre_reset rgb=%b hs=%b vs=%b de=%b want 110000/1/1/1", rgb, hsync, vsync, de);
    end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    n_cmp++;
    if ({rgb, hsync, vsync, de} !== 9'b0) begin
      n_err++; $display("FAIL async_reset got=%b want=%b", {rgb, hsync, vsync, de}, 9'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    show(110, 110, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b000001) begin
      n_err++; $display("FAIL post_reset_bg rgb=%b want=000001", rgb);
    end
    hits0 = 8'd2;
    tick();
    show(110, 110, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rgb !== 6'b110000) begin
      n_err++; $display("FAIL first_tick_no_flash rgb=%b want=110000", rgb);
    end
  endtask

  initial begin
    test_reset();
    test_two_dogs();
    test_overlap();
    test_no_tearing();
    test_tick_coincident();
    test_edges();
    test_flash();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
